// File: rtl/ssp_pkg.sv
// Shared SSP definitions: data/FIFO sizing and the transmit FSM state encoding.
package ssp_pkg;

  localparam int SSP_DATA_W       = 8;
  localparam int SSP_TXFIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LAUNCH     = 2'd1,
    WAIT_START = 2'd2,
    SHIFTING   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/ssp_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module ssp_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: buffers APB bytes and hands them to trlogic one at a time,
// retiring each byte only once trlogic reports the transfer complete.
module ssp_tx_fifo
  import ssp_pkg::*;
#(
  parameter int DEPTH = SSP_TXFIFO_DEPTH,
  parameter int WIDTH = SSP_DATA_W,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             PCLK,
  input  logic             CLEAR,
  input  logic             PSEL,
  input  logic             PWRITE,
  input  logic [WIDTH-1:0] PWDATA,
  input  logic             transmit_complete,
  output logic [WIDTH-1:0] TxData,
  output logic             tx_ready,
  output logic             SSPTXINTR,
  output logic             tx_empty,
  output logic             tx_full,
  output logic             tx_overflow
);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  tx_state_e        state, next_state;
  logic             wr_req, push, pop, launch;

  assign tx_empty  = (count == '0);
  assign tx_full   = (count == (PTR_W+1)'(DEPTH));
  assign SSPTXINTR = (count <= (PTR_W+1)'(DEPTH/2));

  // Full is judged on the registered count, so a pop in the same cycle
  // does not make room for a concurrent push.
  assign wr_req = PSEL & PWRITE;
  assign push   = wr_req & ~tx_full;
  assign pop    = (state == SHIFTING) & transmit_complete;

  ssp_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (PCLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (PWDATA),
    .raddr (rd_ptr),
    .rdata (TxData)
  );

  always_comb begin
    next_state = state;
    launch     = 1'b0;
    case (state)
      IDLE: if (!tx_empty && transmit_complete) begin
        next_state = LAUNCH;
        launch     = 1'b1;
      end
      LAUNCH:     next_state = WAIT_START;
      WAIT_START: if (!transmit_complete) next_state = SHIFTING;
      SHIFTING:   if (transmit_complete) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      state    <= IDLE;
      tx_ready <= 1'b0;
    end else begin
      state    <= next_state;
      tx_ready <= launch;
    end
  end

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_req && tx_full) tx_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ssp_tx_fifo.sv
// Directed vector bench for ssp_tx_fifo with a hand-scripted trlogic handshake.
module tb_ssp_tx_fifo;
  import ssp_pkg::*;

  logic       PCLK = 1'b0;
  logic       CLEAR;
  logic       PSEL, PWRITE;
  logic [7:0] PWDATA;
  logic       transmit_complete;
  logic [7:0] TxData;
  logic       tx_ready, SSPTXINTR, tx_empty, tx_full, tx_overflow;

  ssp_tx_fifo dut (
    .PCLK              (PCLK),
    .CLEAR             (CLEAR),
    .PSEL              (PSEL),
    .PWRITE            (PWRITE),
    .PWDATA            (PWDATA),
    .transmit_complete (transmit_complete),
    .TxData            (TxData),
    .tx_ready          (tx_ready),
    .SSPTXINTR         (SSPTXINTR),
    .tx_empty          (tx_empty),
    .tx_full           (tx_full),
    .tx_overflow       (tx_overflow)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic       psel;
    logic       pwrite;
    logic [7:0] wd;
    logic       tc;
    logic       rdy;
    logic [2:0] cnt;
    logic       ovf;
    logic       ck;
    logic [7:0] d;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nbad = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic ps, input logic pw, input logic [7:0] wd, input logic tc,
                     input logic rdy, input int cnt, input logic ovf, input logic ck,
                     input logic [7:0] d);
    vec_t v;
    v.psel = ps; v.pwrite = pw; v.wd = wd; v.tc = tc; v.rdy = rdy;
    v.cnt = 3'(cnt); v.ovf = ovf; v.ck = ck; v.d = d;
    vecs.push_back(v);
  endtask

  // Push with data check, and a no-push cycle.
  task automatic P(input logic [7:0] wd, input logic tc, input logic rdy, input int cnt,
                   input logic ovf, input logic [7:0] d);
    add(1'b1, 1'b1, wd, tc, rdy, cnt, ovf, 1'b1, d);
  endtask

  task automatic N(input logic tc, input logic rdy, input int cnt, input logic ovf,
                   input logic ck, input logic [7:0] d);
    add(1'b0, 1'b0, 8'h00, tc, rdy, cnt, ovf, ck, d);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    PSEL = v.psel; PWRITE = v.pwrite; PWDATA = v.wd; transmit_complete = v.tc;
    @(posedge PCLK);
    #1;
    chk($sformatf("v%0d tx_ready", i),    8'(tx_ready),    8'(v.rdy));
    chk($sformatf("v%0d count", i),       8'(dut.count),   8'(v.cnt));
    chk($sformatf("v%0d tx_empty", i),    8'(tx_empty),    8'(v.cnt == 3'd0));
    chk($sformatf("v%0d tx_full", i),     8'(tx_full),     8'(v.cnt == 3'd4));
    chk($sformatf("v%0d SSPTXINTR", i),   8'(SSPTXINTR),   8'(v.cnt <= 3'd2));
    chk($sformatf("v%0d tx_overflow", i), 8'(tx_overflow), 8'(v.ovf));
    if (v.ck) chk($sformatf("v%0d TxData", i), TxData, v.d);
  endtask

  int a0, e0, e1, d0, d5, d16, d_end;

  initial begin
    CLEAR = 1'b1; PSEL = 1'b0; PWRITE = 1'b0; PWDATA = 8'h00; transmit_complete = 1'b1;

    // Single byte: launch N+1..N+2, then an 8-cycle shift.
    a0 = vecs.size();
    P(8'hA5, 1, 0, 1, 0, 8'hA5);
    N(1, 1, 1, 0, 1, 8'hA5);
    N(1, 0, 1, 0, 1, 8'hA5);
    for (int k = 0; k < 7; k++) N(0, 0, 1, 0, 1, 8'hA5);
    N(1, 0, 0, 0, 0, 8'h00);
    N(1, 0, 0, 0, 0, 8'h00);
    // Fill to full, overflow, push during full-pop dropped, drain in order.
    P(8'h11, 1, 0, 1, 0, 8'h11);
    P(8'h22, 1, 1, 2, 0, 8'h11);
    P(8'h33, 1, 0, 3, 0, 8'h11);
    P(8'h44, 1, 0, 4, 0, 8'h11);
    P(8'h55, 0, 0, 4, 1, 8'h11);
    N(0, 0, 4, 1, 1, 8'h11);
    P(8'h66, 1, 0, 3, 1, 8'h22);
    N(1, 1, 3, 1, 1, 8'h22);
    N(1, 0, 3, 1, 1, 8'h22);
    N(0, 0, 3, 1, 1, 8'h22);
    N(1, 0, 2, 1, 1, 8'h33);
    N(1, 1, 2, 1, 1, 8'h33);
    N(1, 0, 2, 1, 1, 8'h33);
    N(0, 0, 2, 1, 1, 8'h33);
    N(1, 0, 1, 1, 1, 8'h44);
    N(1, 1, 1, 1, 1, 8'h44);
    N(1, 0, 1, 1, 1, 8'h44);
    N(0, 0, 1, 1, 1, 8'h44);
    N(1, 0, 0, 1, 0, 8'h00);
    // trlogic busy while a byte arrives; non-push APB cycles ignored.
    P(8'h3C, 0, 0, 1, 1, 8'h3C);
    add(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'h3C);
    add(1'b0, 1'b1, 8'hDD, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'h3C);
    N(1, 1, 1, 1, 1, 8'h3C);
    N(1, 0, 1, 1, 1, 8'h3C);
    N(0, 0, 1, 1, 1, 8'h3C);
    N(1, 0, 0, 1, 0, 8'h00);
    // Reach SHIFTING with three entries.
    P(8'h01, 1, 0, 1, 1, 8'h01);
    P(8'h02, 1, 1, 2, 1, 8'h01);
    P(8'h03, 1, 0, 3, 1, 8'h01);
    N(0, 0, 3, 1, 1, 8'h01);
    // After CLEAR: late completion must not pop; fresh byte lands at entry 0.
    e0 = vecs.size();
    N(0, 0, 0, 0, 0, 8'h00);
    N(0, 0, 0, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) N(1, 0, 0, 0, 0, 8'h00);
    P(8'h77, 1, 0, 1, 0, 8'h77);
    N(1, 1, 1, 0, 1, 8'h77);
    N(1, 0, 1, 0, 1, 8'h77);
    N(0, 0, 1, 0, 1, 8'h77);
    N(1, 0, 0, 0, 0, 8'h00);
    e1 = vecs.size();
    // Simultaneous push/pop with pointer wrap, six bytes B0..B5.
    d0 = vecs.size();
    P(8'hB0, 1, 0, 1, 0, 8'hB0);
    P(8'hB1, 1, 1, 2, 0, 8'hB0);
    N(1, 0, 2, 0, 1, 8'hB0);
    N(0, 0, 2, 0, 1, 8'hB0);
    P(8'hB2, 1, 0, 2, 0, 8'hB1);
    P(8'hB3, 1, 1, 3, 0, 8'hB1);
    d5 = vecs.size() - 1;
    N(1, 0, 3, 0, 1, 8'hB1);
    N(0, 0, 3, 0, 1, 8'hB1);
    P(8'hB4, 1, 0, 3, 0, 8'hB2);
    N(1, 1, 3, 0, 1, 8'hB2);
    N(1, 0, 3, 0, 1, 8'hB2);
    N(0, 0, 3, 0, 1, 8'hB2);
    N(1, 0, 2, 0, 1, 8'hB3);
    P(8'hB5, 1, 1, 3, 0, 8'hB3);
    N(1, 0, 3, 0, 1, 8'hB3);
    N(0, 0, 3, 0, 1, 8'hB3);
    N(1, 0, 2, 0, 1, 8'hB4);
    d16 = vecs.size() - 1;
    N(1, 1, 2, 0, 1, 8'hB4);
    N(1, 0, 2, 0, 1, 8'hB4);
    N(0, 0, 2, 0, 1, 8'hB4);
    N(1, 0, 1, 0, 1, 8'hB5);
    N(1, 1, 1, 0, 1, 8'hB5);
    N(1, 0, 1, 0, 1, 8'hB5);
    N(0, 0, 1, 0, 1, 8'hB5);
    N(1, 0, 0, 0, 0, 8'h00);
    d_end = vecs.size();

    // Reset state.
    #12;
    chk("rst tx_ready",    8'(tx_ready),    8'h00);
    chk("rst tx_empty",    8'(tx_empty),    8'h01);
    chk("rst tx_full",     8'(tx_full),     8'h00);
    chk("rst SSPTXINTR",   8'(SSPTXINTR),   8'h01);
    chk("rst tx_overflow", 8'(tx_overflow), 8'h00);
    chk("rst count",       8'(dut.count),   8'h00);
    @(negedge PCLK);
    CLEAR = 1'b0;

    for (int i = a0; i < e0; i++) run_vec(i);

    // CLEAR mid-shift, checked before the next clock edge.
    chk("pre-clr state", 8'(dut.state), 8'(SHIFTING));
    transmit_complete = 1'b0;
    #2 CLEAR = 1'b1;
    #1;
    chk("clr tx_ready",    8'(tx_ready),    8'h00);
    chk("clr count",       8'(dut.count),   8'h00);
    chk("clr tx_empty",    8'(tx_empty),    8'h01);
    chk("clr tx_full",     8'(tx_full),     8'h00);
    chk("clr SSPTXINTR",   8'(SSPTXINTR),   8'h01);
    chk("clr tx_overflow", 8'(tx_overflow), 8'h00);
    chk("clr state",       8'(dut.state),   8'(IDLE));
    @(posedge PCLK);
    #1 CLEAR = 1'b0;

    for (int i = e0; i < e1; i++) run_vec(i);

    @(negedge PCLK);
    CLEAR = 1'b1;
    @(negedge PCLK);
    CLEAR = 1'b0;

    for (int i = d0; i < d_end; i++) begin
      run_vec(i);
      if (i == d5)  chk("wrap wr_ptr", 8'(dut.wr_ptr), 8'h00);
      if (i == d16) begin
        chk("wrap rd_ptr",  8'(dut.rd_ptr), 8'h00);
        chk("wrap wr_ptr2", 8'(dut.wr_ptr), 8'h02);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
